// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: state encodings and grant IDs shared by the memory arbiter.
package mem_arb_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, RESP_I = 2'd1, RESP_D = 2'd2} state_t;
    localparam logic GNT_I = 1'b0;
    localparam logic GNT_D = 1'b1;
endpackage

// File: rtl/mem_arb_decode.sv
// mem_arb_decode: byte address to {word index, in-range}; byte offset is dropped.
module mem_arb_decode #(
    parameter int MEM_WORDS = 256,
    parameter int AW = 8
) (
    input  logic [31:0]   addr,
    output logic [AW-1:0] idx,
    output logic          ok
);
    logic unused_lsb;
    assign unused_lsb = ^addr[1:0];
    assign idx = addr[AW+1:2];
    assign ok = addr[31:2] < 30'(MEM_WORDS);
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one synchronous-read RAM between fetch and load/store ports.
// MEM_ARB_RR_EN selects round-robin on ties; default is data-over-fetch priority.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int MEM_WORDS = 256,
    parameter int AW = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_req,
    input  logic [31:0]   i_addr,
    output logic          i_gnt,
    output logic          i_rvalid,
    output logic [31:0]   i_rdata,
    output logic          i_err,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [3:0]    d_wmask,
    input  logic [31:0]   d_addr,
    input  logic [31:0]   d_wdata,
    output logic          d_gnt,
    output logic          d_rvalid,
    output logic [31:0]   d_rdata,
    output logic          d_err,
    output logic          mem_en,
    output logic [3:0]    mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    input  logic [31:0]   mem_rdata
);
    state_t state, state_n;
    logic err_q, err_n, rd_q, rd_n, d_win, i_ok, d_ok;
    logic [AW-1:0] i_idx, d_idx;

    mem_arb_decode #(.MEM_WORDS(MEM_WORDS), .AW(AW)) u_dec_i (.addr(i_addr), .idx(i_idx), .ok(i_ok));
    mem_arb_decode #(.MEM_WORDS(MEM_WORDS), .AW(AW)) u_dec_d (.addr(d_addr), .idx(d_idx), .ok(d_ok));

`ifdef MEM_ARB_RR_EN
    logic last;
    // On a tie, fetch wins only if data took the previous grant
    assign d_win = d_req && !(i_req && last == GNT_D);
    always_ff @(posedge clk) begin
        if (reset) last <= GNT_I;
        else if (d_gnt || i_gnt) last <= d_gnt ? GNT_D : GNT_I;
    end
`else
    assign d_win = d_req;
`endif

    always_comb begin
        d_gnt = d_win && !reset;
        i_gnt = i_req && !d_win && !reset;
        state_n = d_gnt ? RESP_D : i_gnt ? RESP_I : IDLE;
        err_n = d_gnt ? !d_ok : (i_gnt && !i_ok);
        rd_n = !(d_gnt && d_we);
        mem_en = d_gnt ? d_ok : (i_gnt && i_ok);
        mem_addr = d_gnt ? d_idx : i_idx;
        mem_we = (d_gnt && d_ok && d_we) ? d_wmask : 4'b0;
        mem_wdata = d_wdata;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            err_q <= 1'b0;
            rd_q <= 1'b0;
        end else begin
            state <= state_n;
            err_q <= err_n;
            rd_q <= rd_n;
        end
    end

    // Gating with reset drops a response whose grant preceded a reset
    assign i_rvalid = state == RESP_I && !reset;
    assign d_rvalid = state == RESP_D && !reset;
    assign i_err = i_rvalid && err_q;
    assign d_err = d_rvalid && err_q;
    assign i_rdata = (i_rvalid && !err_q) ? mem_rdata : 32'h0;
    assign d_rdata = (d_rvalid && rd_q && !err_q) ? mem_rdata : 32'h0;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed stimulus with a queue scoreboard per response port.
module tb_mem_arbiter;
    logic clk = 1'b0, reset = 1'b1;
    logic i_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
    logic [31:0] i_addr = '0, d_addr = '0, d_wdata = '0;
    logic [3:0] d_wmask = '0;
    logic i_gnt, i_rvalid, i_err, d_gnt, d_rvalid, d_err, mem_en;
    logic [31:0] i_rdata, d_rdata, mem_wdata;
    logic [31:0] mem_rdata = '0;
    logic [3:0] mem_we;
    logic [7:0] mem_addr;

    typedef struct {logic [31:0] data; logic err;} resp_t;
    resp_t iq[$], dq[$];
    int checks = 0, errors = 0;
    logic [31:0] ram [256];

    mem_arbiter dut (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata), .i_err(i_err),
        .d_req(d_req), .d_we(d_we), .d_wmask(d_wmask), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_en) begin
            for (int b = 0; b < 4; b++)
                if (mem_we[b]) ram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
            mem_rdata <= ram[mem_addr];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        resp_t r;
        if (i_rvalid) begin
            if (iq.size() == 0) chk("i_rvalid_unexpected", 32'(i_rvalid), 0);
            else begin
                r = iq.pop_front();
                chk("i_rdata", i_rdata, r.data);
                chk("i_err", 32'(i_err), 32'(r.err));
            end
        end else chk("i_rdata_idle", i_rdata, 0);
        if (d_rvalid) begin
            if (dq.size() == 0) chk("d_rvalid_unexpected", 32'(d_rvalid), 0);
            else begin
                r = dq.pop_front();
                chk("d_rdata", d_rdata, r.data);
                chk("d_err", 32'(d_err), 32'(r.err));
            end
        end else chk("d_rdata_idle", d_rdata, 0);
    end

    task automatic cyc(input logic ir, input logic [31:0] ia, input logic dr, input logic dwe,
                       input logic [3:0] dm, input logic [31:0] da, input logic [31:0] dw,
                       input logic eig, input logic edg, input logic een, input logic [3:0] ewe,
                       input logic [7:0] eaddr, input logic [31:0] erd, input logic eerr);
        i_req = ir; i_addr = ia; d_req = dr; d_we = dwe; d_wmask = dm; d_addr = da; d_wdata = dw;
        #1;
        chk("i_gnt", 32'(i_gnt), 32'(eig));
        chk("d_gnt", 32'(d_gnt), 32'(edg));
        chk("mem_en", 32'(mem_en), 32'(een));
        chk("mem_we", 32'(mem_we), 32'(ewe));
        if (een) chk("mem_addr", 32'(mem_addr), 32'(eaddr));
        if (een && ewe != 0) chk("mem_wdata", mem_wdata, dw);
        if (eig) iq.push_back('{erd, eerr});
        if (edg) dq.push_back('{erd, eerr});
        @(negedge clk);
    endtask

    initial begin
        for (int k = 0; k < 256; k++) ram[k] = 32'h0;
        ram[0] = 32'hA0; ram[1] = 32'hA1; ram[2] = 32'hA2;
        ram[4] = 32'h0010_0093; ram[8] = 32'h1122_3344; ram[12] = 32'h5566_7788;
        i_req = 1'b1; i_addr = 32'h10;
        @(negedge clk); #1;
        chk("rst_mem_en", 32'(mem_en), 0);
        chk("rst_i_gnt", 32'(i_gnt), 0);
        @(negedge clk);
        reset = 1'b0; i_req = 1'b0;
        #1;
        chk("rst_i_rvalid", 32'(i_rvalid), 0);
        chk("rst_d_rvalid", 32'(d_rvalid), 0);
        chk("rst_i_err", 32'(i_err), 0);
        chk("rst_d_err", 32'(d_err), 0);
        chk("rst_mem_we", 32'(mem_we), 0);
        @(negedge clk);
        // single fetch, store then load, zero-mask store
        cyc(1, 32'h10, 0, 0, 0, 0, 0,                     1, 0, 1, 0, 8'd4, 32'h0010_0093, 0);
        cyc(0, 0, 0, 0, 0, 0, 0,                          0, 0, 0, 0, 8'd0, 0, 0);
        cyc(0, 0, 1, 1, 4'b0011, 32'h20, 32'hAABB_CCDD,   0, 1, 1, 4'b0011, 8'd8, 0, 0);
        cyc(0, 0, 1, 0, 0, 32'h20, 0,                     0, 1, 1, 0, 8'd8, 32'h1122_CCDD, 0);
        cyc(0, 0, 1, 1, 4'b0000, 32'h30, 32'hFFFF_FFFF,   0, 1, 1, 0, 8'd12, 0, 0);
        cyc(0, 0, 1, 0, 0, 32'h30, 0,                     0, 1, 1, 0, 8'd12, 32'h5566_7788, 0);
        cyc(1, 32'h10, 0, 0, 0, 0, 0,                     1, 0, 1, 0, 8'd4, 32'h0010_0093, 0);
        // contention
        for (int k = 0; k < 4; k++) begin
`ifdef MEM_ARB_RR_EN
            if (k % 2 == 1) cyc(1, 32'h10, 1, 0, 0, 32'h20, 0, 1, 0, 1, 0, 8'd4, 32'h0010_0093, 0);
            else cyc(1, 32'h10, 1, 0, 0, 32'h20, 0, 0, 1, 1, 0, 8'd8, 32'h1122_CCDD, 0);
`else
            cyc(1, 32'h10, 1, 0, 0, 32'h20, 0, 0, 1, 1, 0, 8'd8, 32'h1122_CCDD, 0);
`endif
        end
        cyc(1, 32'h10, 0, 0, 0, 0, 0,                     1, 0, 1, 0, 8'd4, 32'h0010_0093, 0);
        // out of range
        cyc(0, 0, 1, 0, 0, 32'h400, 0,                    0, 1, 0, 0, 8'd0, 0, 1);
        cyc(0, 0, 1, 1, 4'b1111, 32'h8000_0000, 32'h1,    0, 1, 0, 0, 8'd0, 0, 1);
        cyc(1, 32'h1000_0000, 0, 0, 0, 0, 0,              1, 0, 0, 0, 8'd0, 0, 1);
        // back-to-back fetches, misaligned address truncated
        cyc(1, 32'h0, 0, 0, 0, 0, 0,                      1, 0, 1, 0, 8'd0, 32'hA0, 0);
        cyc(1, 32'h4, 0, 0, 0, 0, 0,                      1, 0, 1, 0, 8'd1, 32'hA1, 0);
        cyc(1, 32'hB, 0, 0, 0, 0, 0,                      1, 0, 1, 0, 8'd2, 32'hA2, 0);
        // reset in the cycle after a fetch grant
        i_req = 1'b1; i_addr = 32'h10;
        #1 chk("pre_rst_i_gnt", 32'(i_gnt), 1);
        @(posedge clk); #1;
        reset = 1'b1; i_req = 1'b0;
        #1;
        chk("mid_rst_i_rvalid", 32'(i_rvalid), 0);
        chk("mid_rst_i_rdata", i_rdata, 0);
        chk("mid_rst_mem_en", 32'(mem_en), 0);
        @(posedge clk); #1;
        chk("rst_hold_i_rvalid", 32'(i_rvalid), 0);
        @(negedge clk);
        reset = 1'b0;
        #1 chk("post_rst_i_rvalid", 32'(i_rvalid), 0);
        @(negedge clk);
        cyc(1, 32'h10, 0, 0, 0, 0, 0,                     1, 0, 1, 0, 8'd4, 32'h0010_0093, 0);
        cyc(0, 0, 0, 0, 0, 0, 0,                          0, 0, 0, 0, 8'd0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0,                          0, 0, 0, 0, 8'd0, 0, 0);
        chk("ram12_untouched", ram[12], 32'h5566_7788);
        chk("iq_drained", iq.size(), 0);
        chk("dq_drained", dq.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Single-port memory arbiter that shares the SOC's 256-word (1 KiB) instruction/data RAM between the core's instruction-fetch port and its load/store port. Every access runs through a grant/response handshake. The block turns byte addresses into word indices and byte-lane write masks, and flags out-of-range accesses. It sits between the core's fetch/execute state machine and the synchronous-read `MEM` array, replacing direct `MEM[PC[31:2]]` indexing.

## Interface
Parameters:
- `MEM_WORDS`, 256, number of 32-bit words; must be a power of two.
- `AW`, 8, word-index width, equal to log2(`MEM_WORDS`).

Ports:
- `clk`  in  1  system clock (the `Clockworks` output).
- `reset`  in  1  synchronous, active-high reset.
- `i_req`  in  1  fetch request; held with `i_addr` until `i_gnt`.
- `i_addr`  in  32  fetch byte address.
- `i_gnt`  out  1  fetch request accepted this cycle.
- `i_rvalid`  out  1  fetch response valid.
- `i_rdata`  out  32  fetched instruction word.
- `i_err`  out  1  fetch address out of range; qualified by `i_rvalid`.
- `d_req`  in  1  data request; held with all `d_*` inputs until `d_gnt`.
- `d_we`  in  1  1 = store, 0 = load.
- `d_wmask`  in  4  byte-lane write enables for stores.
- `d_addr`  in  32  data byte address.
- `d_wdata`  in  32  store data.
- `d_gnt`  out  1  data request accepted this cycle.
- `d_rvalid`  out  1  data response valid (load data or store ack).
- `d_rdata`  out  32  load data.
- `d_err`  out  1  data address out of range; qualified by `d_rvalid`.
- `mem_en`  out  1  RAM access strobe.
- `mem_we`  out  4  RAM byte write enables.
- `mem_addr`  out  AW  RAM word index.
- `mem_wdata`  out  32  RAM write data.
- `mem_rdata`  in  32  RAM read data, valid one cycle after `mem_en`.

Clock is `clk`; reset is `reset`, synchronous, active-high.

## Operation
State machine, recording which port owns the outstanding access:
- `IDLE`: nothing outstanding.
- `RESP_I`: fetch outstanding.
- `RESP_D`: data outstanding.

Arbitration:
- Arbitration runs every cycle, including the cycle in which a response is returned, so back-to-back accesses are supported.
- On a grant, the state moves to `RESP_I` or `RESP_D` according to the winner.
- With no grant, the state returns to `IDLE`.
- Default policy is fixed priority: data wins over fetch.

Address decode:
- Word index is `addr[AW+1:2]`.
- `addr[1:0]` is ignored, so misaligned addresses are truncated to the word.
- An address is in range iff `addr[31:AW+2] == 0`.

Granted in-range access:
- `mem_en` = 1 and `mem_addr` = word index.
- For a store: `mem_we` = `d_wmask` and `mem_wdata` = `d_wdata`.
- For a fetch or load: `mem_we` = 0.

Granted out-of-range access:
- `mem_en` = 0 and `mem_we` = 0.
- The response is still returned with `*_err` = 1 and rdata = 0.

Response:
- The owning port's `*_rvalid` pulses for exactly one cycle.
- `*_rdata` = `mem_rdata` for an in-range read. Otherwise it is 0, including for store acks.
- `*_rdata` is 0 whenever `*_rvalid` = 0.

Boundary conditions:
- A store with `d_wmask` = 0 is a legal no-op: it is granted and acked, and `mem_en` = 1 with `mem_we` = 0.
- Simultaneous requests: exactly one grant per cycle, and the loser sees `*_gnt` = 0 and keeps requesting.
- Reset mid-access: the outstanding response is dropped, and no `*_rvalid` appears in the cycle after reset.

## Timing
- `*_gnt` and `mem_*` are combinational from the requests in the same cycle.
- `*_rvalid` and `*_err` are registered, asserted exactly one cycle after the grant.
- `*_rdata` is combinational from `mem_rdata` during the rvalid cycle.
- Latency is request to response in 1 cycle; peak throughput is 1 access/cycle.
- Reset values: state `IDLE`, all `*_gnt`/`*_rvalid`/`*_err` = 0, `mem_en` = 0, `mem_we` = 0.
- While reset is asserted, `mem_en` stays 0 regardless of requests.

## Configuration
Macro `MEM_ARB_RR_EN`:
- Defined: round-robin arbitration with a 1-bit last-grant register. On simultaneous requests, the port not granted last wins. Reset sets last-grant = fetch, so data wins the first tie.
- Undefined: fixed data-over-fetch priority, and no last-grant register is built.
- Single-requester behaviour is identical in both builds.

## Structure
Package `mem_arb_pkg` holds:
- the state encodings `IDLE` = 0, `RESP_I` = 1, `RESP_D` = 2;
- the grant-ID constants `GNT_I`, `GNT_D`.

One sub-module is natural: `mem_arb_decode`, purely combinational. It maps a byte address to `{word index, in-range}` and is instantiated once per port.

The arbiter FSM and response registers live in `mem_arbiter`.

## Test plan
- **Single fetch:** `i_req` = 1, `i_addr` = 0x0000_0010, RAM[4] = 0x0010_0093 -> `i_gnt` and `mem_addr` = 4 in the same cycle; next cycle `i_rvalid` = 1, `i_rdata` = 0x0010_0093, `i_err` = 0.
- **Store then load:** first a store with `d_addr` = 0x0000_0020, `d_wmask` = 4'b0011, `d_wdata` = 0xAABB_CCDD on a RAM word of 0x1122_3344. Then a load of 0x20 -> the store is acked with rdata 0; the load returns 0x1122_CCDD.
- **Contention:** `i_req` and `d_req` both high for 4 cycles -> default build grants d every cycle and i never; with `MEM_ARB_RR_EN`, grants alternate d, i, d, i, each response arriving one cycle later on the matching port.
- **Out of range:** `d_addr` = 0x0000_0400 -> `d_gnt` = 1 and `mem_en` = 0; next cycle `d_rvalid` = 1, `d_err` = 1, `d_rdata` = 0.
- **Back-to-back fetches:** `i_req` held with `i_addr` = 0, 4, 8 on consecutive grants -> `i_rvalid` is high for 3 consecutive cycles, data in order.
- **Reset mid-access:** `reset` is asserted in the cycle after a fetch grant -> no `i_rvalid`, all outputs 0; the first request after reset is served normally.
